// File: rtl/l1_cache_if.sv
// CPU-side and L2-side handshake bundle for the L1 data cache controller.
// The controller connects through the slave modport; the agent that drives
// CPU requests and plays the L2 role uses the master modport.
interface l1_cache_if;
    // CPU request / response
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic        cpu_req_we;
    logic [31:0] cpu_req_addr;
    logic [31:0] cpu_req_wdata;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_rdata;

    // L2 request / refill response
    logic        l2_req_valid;
    logic        l2_req_ready;
    logic        l2_req_we;
    logic [31:0] l2_req_addr;
    logic [31:0] l2_req_wdata;
    logic        l2_resp_valid;
    logic [31:0] l2_resp_rdata;

    modport slave (
        input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
        input  l2_req_ready, l2_resp_valid, l2_resp_rdata,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
        output l2_req_valid, l2_req_we, l2_req_addr, l2_req_wdata
    );

    modport master (
        output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
        output l2_req_ready, l2_resp_valid, l2_resp_rdata,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
        input  l2_req_valid, l2_req_we, l2_req_addr, l2_req_wdata
    );
endinterface

// File: rtl/l1_cache_ctrl.sv
// Direct-mapped, write-through, read-allocate L1 data cache with its
// controller FSM. Lines hold four 32-bit words. Read misses refill the whole
// line from L2 in four beats; writes always go through to L2 and only update
// the local copy when the line is already present.
module l1_cache_ctrl #(
    parameter int LINES   = 256,
    parameter int INDEX_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    l1_cache_if.slave   bus,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int TAG_W = 28 - INDEX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL_REQ,
        REFILL_WAIT,
        WRITE_REQ,
        RESP
    } state_t;

    state_t             state_reg;

    // Request captured in IDLE; stays constant for the whole transaction.
    logic [TAG_W-1:0]   req_tag_reg;
    logic [INDEX_W-1:0] req_index_reg;
    logic [1:0]         req_word_reg;
    logic               req_we_reg;
    logic [31:0]        req_wdata_reg;

    // Per-line valid bits live in flops so reset can clear them all at once.
    logic [LINES-1:0]   valid_reg;

    // Refill bookkeeping.
    logic [1:0]         beat_reg;
    logic [31:0]        fill_word_reg;

    // Tag store and the four word lanes of the data store.
    logic [TAG_W-1:0]   tag_mem [LINES];
    logic [TAG_W-1:0]   tag_rd_reg;
    logic               tag_we;
    logic [31:0]        bank_rd [4];
    logic [3:0]         bank_we;
    logic [31:0]        bank_wdata;

    // Arrays are read at the acceptance edge so the lookup cycle sees
    // registered tag and data without a combinational RAM read.
    logic               rd_en;
    logic [INDEX_W-1:0] cpu_index;
    logic               hit;
    logic [31:0]        hit_word;

    // Byte offset within a word is meaningless to a word-granular cache.
    logic [1:0]         unused_addr_bits;
    assign unused_addr_bits = bus.cpu_req_addr[1:0];

    assign rd_en     = (state_reg == IDLE) && bus.cpu_req_valid;
    assign cpu_index = bus.cpu_req_addr[INDEX_W+3:4];
    assign hit       = valid_reg[req_index_reg] && (tag_rd_reg == req_tag_reg);
    assign hit_word  = bank_rd[req_word_reg];

    // Ready is decoded from state only, so no input reaches it combinationally.
    assign bus.cpu_req_ready = (state_reg == IDLE);

    // The tag is written once, together with the last refill beat.
    assign tag_we = (state_reg == REFILL_WAIT) && bus.l2_resp_valid && (beat_reg == 2'd3);

    // Select which word lane is written: a write hit updates the addressed
    // word, a refill beat fills the lane matching the beat number.
    always_comb begin
        bank_we    = '0;
        bank_wdata = req_wdata_reg;
        if ((state_reg == LOOKUP) && req_we_reg && hit) begin
            bank_we[req_word_reg] = 1'b1;
        end else if ((state_reg == REFILL_WAIT) && bus.l2_resp_valid) begin
            bank_we[beat_reg] = 1'b1;
            bank_wdata        = bus.l2_resp_rdata;
        end
    end

    // Tag store: one write port (refill), one registered read port (accept).
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_mem[req_index_reg] <= req_tag_reg;
        end
        if (rd_en) begin
            tag_rd_reg <= tag_mem[cpu_index];
        end
    end

    // One block RAM per word lane, all addressed by the line index.
    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
        logic [31:0] mem [LINES];
        logic [31:0] rd_reg;

        // Lane write from refill/write hit, registered read at acceptance.
        always_ff @(posedge clk) begin
            if (bank_we[gi]) begin
                mem[req_index_reg] <= bank_wdata;
            end
            if (rd_en) begin
                rd_reg <= mem[cpu_index];
            end
        end

        assign bank_rd[gi] = rd_reg;
    end

    // Controller FSM with registered CPU/L2 outputs and statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= IDLE;
            req_tag_reg        <= '0;
            req_index_reg      <= '0;
            req_word_reg       <= '0;
            req_we_reg         <= 1'b0;
            req_wdata_reg      <= '0;
            valid_reg          <= '0;
            beat_reg           <= '0;
            fill_word_reg      <= '0;
            hit_count          <= '0;
            miss_count         <= '0;
            bus.cpu_resp_valid <= 1'b0;
            bus.cpu_resp_rdata <= '0;
            bus.l2_req_valid   <= 1'b0;
            bus.l2_req_we      <= 1'b0;
            bus.l2_req_addr    <= '0;
            bus.l2_req_wdata   <= '0;
        end else begin
            bus.cpu_resp_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.cpu_req_valid) begin
                        req_tag_reg   <= bus.cpu_req_addr[31:INDEX_W+4];
                        req_index_reg <= bus.cpu_req_addr[INDEX_W+3:4];
                        req_word_reg  <= bus.cpu_req_addr[3:2];
                        req_we_reg    <= bus.cpu_req_we;
                        req_wdata_reg <= bus.cpu_req_wdata;
                        state_reg     <= LOOKUP;
                    end
                end

                LOOKUP: begin
                    if (hit) begin
                        hit_count <= hit_count + 32'd1;
                    end else begin
                        miss_count <= miss_count + 32'd1;
                    end

                    if (req_we_reg) begin
                        // Write-through regardless of hit; the lane update
                        // for a hit happens in this same cycle.
                        bus.l2_req_valid <= 1'b1;
                        bus.l2_req_we    <= 1'b1;
                        bus.l2_req_addr  <= {req_tag_reg, req_index_reg, req_word_reg, 2'b00};
                        bus.l2_req_wdata <= req_wdata_reg;
                        state_reg        <= WRITE_REQ;
                    end else if (hit) begin
                        bus.cpu_resp_valid <= 1'b1;
                        bus.cpu_resp_rdata <= hit_word;
                        state_reg          <= RESP;
                    end else begin
                        // The line is being overwritten: drop its valid bit so
                        // an aborted refill can never leave a stale hit.
                        valid_reg[req_index_reg] <= 1'b0;
                        bus.l2_req_valid <= 1'b1;
                        bus.l2_req_we    <= 1'b0;
                        bus.l2_req_addr  <= {req_tag_reg, req_index_reg, 4'b0000};
                        bus.l2_req_wdata <= '0;
                        beat_reg         <= 2'd0;
                        state_reg        <= REFILL_REQ;
                    end
                end

                REFILL_REQ: begin
                    if (bus.l2_req_ready) begin
                        bus.l2_req_valid <= 1'b0;
                        state_reg        <= REFILL_WAIT;
                    end
                end

                REFILL_WAIT: begin
                    if (bus.l2_resp_valid) begin
                        beat_reg <= beat_reg + 2'd1;
                        if (beat_reg == req_word_reg) begin
                            fill_word_reg <= bus.l2_resp_rdata;
                        end
                        if (beat_reg == 2'd3) begin
                            valid_reg[req_index_reg] <= 1'b1;
                            bus.cpu_resp_valid <= 1'b1;
                            // The requested word may be the beat arriving now.
                            bus.cpu_resp_rdata <= (req_word_reg == 2'd3) ? bus.l2_resp_rdata
                                                                         : fill_word_reg;
                            state_reg <= RESP;
                        end
                    end
                end

                WRITE_REQ: begin
                    if (bus.l2_req_ready) begin
                        bus.l2_req_valid   <= 1'b0;
                        bus.cpu_resp_valid <= 1'b1;
                        bus.cpu_resp_rdata <= '0;
                        state_reg          <= RESP;
                    end
                end

                RESP: begin
                    bus.cpu_resp_rdata <= '0;
                    state_reg          <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Self-checking bench for l1_cache_ctrl: a directed vector table from the
// cache's documented scenarios, a reset-during-refill sequence, and random
// traffic checked against a line-level model of a write-through cache.
module tb_l1_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    always #5 clk = ~clk;

    l1_cache_if bus ();

    l1_cache_ctrl #(.LINES(256), .INDEX_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  hold;
        logic        exp_hit;
        logic        exp_l2_we;
        logic [31:0] exp_l2_addr;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct packed {
        logic        timeout;
        logic        saw_l2;
        logic        l2_we;
        logic [31:0] l2_addr;
        logic [31:0] l2_wdata;
        logic        stable;
        logic [31:0] rdata;
        logic        timing_ok;
        logic [31:0] dh;
        logic [31:0] dm;
    } obs_t;

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;

    // Backing memory as seen by the L2 responder (updated by DUT writes) and
    // the reference memory (updated by CPU writes in program order).
    logic [31:0] l2_mem  [logic [29:0]];
    logic [31:0] ref_mem [logic [29:0]];
    // Model of which tag each line currently holds.
    bit          m_valid [256];
    logic [19:0] m_tag   [256];

    vec_t vecs [12];

    function automatic logic [31:0] init_word(input logic [29:0] wa);
        return {wa[15:0], ~wa[15:0]} ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] l2_rd(input logic [29:0] wa);
        return l2_mem.exists(wa) ? l2_mem[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [29:0] wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h required %08h", name, got, exp);
        end
    endtask

    // Reference model: a direct-mapped write-through cache with read allocate.
    // Since every write reaches memory, a cached word always equals memory.
    task automatic model_step(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, output vec_t e);
        int          idx;
        logic [19:0] tg;
        idx = int'(addr[11:4]);
        tg  = addr[31:12];
        e = '0;
        e.we      = we;
        e.addr    = addr;
        e.wdata   = wdata;
        e.exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        if (we) begin
            ref_mem[addr[31:2]] = wdata;
            e.exp_l2_we   = 1'b1;
            e.exp_l2_addr = {addr[31:2], 2'b00};
            e.exp_rdata   = 32'd0;
        end else begin
            e.exp_l2_we   = 1'b0;
            e.exp_l2_addr = {addr[31:4], 4'b0000};
            e.exp_rdata   = ref_rd(addr[31:2]);
            if (!e.exp_hit) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
            end
        end
    endtask

    // Issue one CPU request and act as L2 until the response pulse.
    // Time t counts clock edges since the acceptance edge, sampled 1ns after.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input int hold, input bit spurious, output obs_t o);
        int n, t, req_t, hs_t, lb_t, resp_t, beats, hold_left;
        bit handshook;
        logic [31:0] h0, m0;
        o = '0;
        o.stable = 1'b1;
        n = 0;
        while (!bus.cpu_req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        h0 = hit_count;
        m0 = miss_count;
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_we    = we;
        bus.cpu_req_addr  = addr;
        bus.cpu_req_wdata = wdata;
        @(posedge clk); #1;
        bus.cpu_req_valid = 1'b0;
        bus.cpu_req_we    = 1'($urandom);
        bus.cpu_req_addr  = $urandom;
        bus.cpu_req_wdata = $urandom;
        req_t = -1; hs_t = -1; lb_t = -1; resp_t = -1;
        beats = 0; hold_left = hold; handshook = 1'b0; t = 1;
        while (resp_t < 0 && t <= 200) begin
            bus.l2_req_ready  = 1'b0;
            bus.l2_resp_valid = 1'b0;
            bus.l2_resp_rdata = $urandom;
            if (bus.cpu_resp_valid) begin
                resp_t  = t;
                o.rdata = bus.cpu_resp_rdata;
            end else begin
                if (bus.l2_req_valid && !handshook) begin
                    if (req_t < 0) begin
                        req_t      = t;
                        o.saw_l2   = 1'b1;
                        o.l2_we    = bus.l2_req_we;
                        o.l2_addr  = bus.l2_req_addr;
                        o.l2_wdata = bus.l2_req_wdata;
                    end else if (bus.l2_req_we !== o.l2_we || bus.l2_req_addr !== o.l2_addr ||
                                 bus.l2_req_wdata !== o.l2_wdata) begin
                        o.stable = 1'b0;
                    end
                    if (hold_left > 0) begin
                        hold_left--;
                        if (spurious && $urandom_range(0, 1) == 1) bus.l2_resp_valid = 1'b1;
                    end else begin
                        bus.l2_req_ready = 1'b1;
                        hs_t = t;
                        handshook = 1'b1;
                        if (o.l2_we) l2_mem[o.l2_addr[31:2]] = o.l2_wdata;
                    end
                end else if (handshook && !o.l2_we && beats < 4) begin
                    if ($urandom_range(0, 2) != 0) begin
                        bus.l2_resp_valid = 1'b1;
                        bus.l2_resp_rdata = l2_rd({o.l2_addr[31:4], beats[1:0]});
                        beats++;
                        if (beats == 4) lb_t = t;
                    end
                end else if (spurious && !handshook && $urandom_range(0, 2) == 0) begin
                    bus.l2_resp_valid = 1'b1;
                end
                @(posedge clk); #1;
                t++;
            end
        end
        bus.l2_req_ready  = 1'b0;
        bus.l2_resp_valid = 1'b0;
        o.timeout = (resp_t < 0);
        o.dh = hit_count - h0;
        o.dm = miss_count - m0;
        if (!o.saw_l2)    o.timing_ok = (resp_t == 2);
        else if (o.l2_we) o.timing_ok = (req_t == 2) && (hs_t > 0) && (resp_t == hs_t + 1);
        else              o.timing_ok = (req_t == 2) && (lb_t > 0) && (resp_t == lb_t + 1);
    endtask

    task automatic check_txn(input string name, input vec_t v, input obs_t o);
        logic needs_l2;
        needs_l2 = v.we || !v.exp_hit;
        check({name, " timeout"}, 32'(o.timeout), 32'd0);
        check({name, " hit_delta"}, o.dh, 32'(v.exp_hit));
        check({name, " miss_delta"}, o.dm, 32'(!v.exp_hit));
        check({name, " l2_req_seen"}, 32'(o.saw_l2), 32'(needs_l2));
        if (needs_l2) begin
            check({name, " l2_we"}, 32'(o.l2_we), 32'(v.exp_l2_we));
            check({name, " l2_addr"}, o.l2_addr, v.exp_l2_addr);
            if (v.we) check({name, " l2_wdata"}, o.l2_wdata, v.wdata);
            check({name, " l2_stable"}, 32'(o.stable), 32'd1);
        end
        check({name, " rdata"}, o.rdata, v.exp_rdata);
        check({name, " timing"}, 32'(o.timing_ok), 32'd1);
        check({name, " hit_count"}, hit_count, exp_hits);
        check({name, " miss_count"}, miss_count, exp_misses);
    endtask

    // Run one transaction; expectations come from the table or from the model.
    task automatic run_one(input string name, input vec_t v, input bit spurious, input bit use_model);
        vec_t e;
        vec_t x;
        obs_t o;
        model_step(v.we, v.addr, v.wdata, e);
        e.hold = v.hold;
        x = use_model ? e : v;
        if (x.exp_hit) exp_hits++;
        else           exp_misses++;
        txn(v.we, v.addr, v.wdata, int'(v.hold), spurious, o);
        n_txn++;
        $display("txn %0d %s: we=%0b addr=%08h wdata=%08h -> rdata=%08h l2=%0b/%08h hits=%0d misses=%0d",
                 n_txn, name, v.we, v.addr, v.wdata, o.rdata, o.saw_l2, o.l2_addr, hit_count, miss_count);
        check_txn(name, x, o);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, " cpu_req_ready"}, 32'(bus.cpu_req_ready), 32'd1);
        check({name, " cpu_resp_valid"}, 32'(bus.cpu_resp_valid), 32'd0);
        check({name, " cpu_resp_rdata"}, bus.cpu_resp_rdata, 32'd0);
        check({name, " l2_req_valid"}, 32'(bus.l2_req_valid), 32'd0);
        check({name, " l2_req_we"}, 32'(bus.l2_req_we), 32'd0);
        check({name, " l2_req_addr"}, bus.l2_req_addr, 32'd0);
        check({name, " l2_req_wdata"}, bus.l2_req_wdata, 32'd0);
        check({name, " hit_count"}, hit_count, 32'd0);
        check({name, " miss_count"}, miss_count, 32'd0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        exp_hits   = '0;
        exp_misses = '0;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1);
    end

    initial begin
        vec_t rv;
        int   n;
        rst = 1'b1;
        bus.cpu_req_valid = 1'b0;
        bus.cpu_req_we    = 1'b0;
        bus.cpu_req_addr  = '0;
        bus.cpu_req_wdata = '0;
        bus.l2_req_ready  = 1'b0;
        bus.l2_resp_valid = 1'b0;
        bus.l2_resp_rdata = '0;
        model_reset();

        for (int i = 0; i < 4; i++) begin
            l2_mem[30'h0000_048C + 30'(i)]  = 32'h0000_00A0 + 32'(i);
            ref_mem[30'h0000_048C + 30'(i)] = 32'h0000_00A0 + 32'(i);
            l2_mem[30'h0000_448C + 30'(i)]  = 32'h0000_00B0 + 32'(i);
            ref_mem[30'h0000_448C + 30'(i)] = 32'h0000_00B0 + 32'(i);
        end

        //            we    addr          wdata         hold  hit   l2we  l2addr        rdata
        vecs[0]  = '{1'b0, 32'h0000_1234, 32'h0,        3'd0, 1'b0, 1'b0, 32'h0000_1230, 32'h0000_00A1};
        vecs[1]  = '{1'b0, 32'h0000_1238, 32'h0,        3'd0, 1'b1, 1'b0, 32'h0,         32'h0000_00A2};
        vecs[2]  = '{1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 3'd1, 1'b1, 1'b1, 32'h0000_1234, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_1234, 32'h0,        3'd0, 1'b1, 1'b0, 32'h0,         32'hDEAD_BEEF};
        vecs[4]  = '{1'b1, 32'h0000_5000, 32'h1234_5678, 3'd3, 1'b0, 1'b1, 32'h0000_5000, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_5000, 32'h0,        3'd3, 1'b0, 1'b0, 32'h0000_5000, 32'h1234_5678};
        vecs[6]  = '{1'b0, 32'h0001_1230, 32'h0,        3'd0, 1'b0, 1'b0, 32'h0001_1230, 32'h0000_00B0};
        vecs[7]  = '{1'b0, 32'h0000_1230, 32'h0,        3'd2, 1'b0, 1'b0, 32'h0000_1230, 32'h0000_00A0};
        vecs[8]  = '{1'b0, 32'h0000_1234, 32'h0,        3'd0, 1'b1, 1'b0, 32'h0,         32'hDEAD_BEEF};
        vecs[9]  = '{1'b1, 32'h0000_123B, 32'h0000_0077, 3'd0, 1'b1, 1'b1, 32'h0000_1238, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_1238, 32'h0,        3'd0, 1'b1, 1'b0, 32'h0,         32'h0000_0077};
        vecs[11] = '{1'b0, 32'h0001_123C, 32'h0,        3'd1, 1'b0, 1'b0, 32'h0001_1230, 32'h0000_00B3};

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("in_reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("after_reset");

        for (int i = 0; i < 12; i++) begin
            run_one($sformatf("vec%0d", i), vecs[i], 1'b0, 1'b0);
        end

        // Reset in the middle of a refill of line 0x23 (held by tag 0x00011).
        n = 0;
        while (!bus.cpu_req_ready && n < 20) begin @(posedge clk); #1; n++; end
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_we    = 1'b0;
        bus.cpu_req_addr  = 32'h0000_1234;
        @(posedge clk); #1;
        bus.cpu_req_valid = 1'b0;
        n = 0;
        while (!bus.l2_req_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("abort l2_req_valid", 32'(bus.l2_req_valid), 32'd1);
        check("abort l2_req_addr", bus.l2_req_addr, 32'h0000_1230);
        bus.l2_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.l2_req_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus.l2_resp_valid = 1'b1;
            bus.l2_resp_rdata = 32'h0000_00C0 + 32'(b);
            @(posedge clk); #1;
        end
        bus.l2_resp_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("mid_refill_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int b = 2; b < 4; b++) begin
            bus.l2_resp_valid = 1'b1;
            bus.l2_resp_rdata = 32'h0000_00C0 + 32'(b);
            @(posedge clk); #1;
        end
        bus.l2_resp_valid = 1'b0;
        check_idle_outputs("late_beats");
        model_reset();
        rv = '0;
        rv.addr = 32'h0000_1234;
        run_one("reread_after_abort", rv, 1'b0, 1'b1);

        // Random traffic over a few indices and tags so hits, conflicts,
        // write hits and write misses all occur.
        for (int k = 0; k < 300; k++) begin
            logic [7:0]  idx;
            logic [19:0] tg;
            rv = '0;
            tg  = 20'($urandom_range(0, 2));
            idx = ($urandom_range(0, 4) == 0) ? 8'h23 : 8'($urandom_range(0, 3));
            rv.addr  = {tg, idx, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            rv.we    = ($urandom_range(0, 9) < 3);
            rv.wdata = $urandom;
            rv.hold  = 3'($urandom_range(0, 3));
            run_one($sformatf("rnd%0d", k), rv, 1'b1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/l1_cache_ctrl.md
# l1_cache_ctrl

Direct-mapped L1 data cache with an integrated controller FSM: 256 lines of 4×32-bit words, tag/valid/data storage, and the sequencing between a CPU request port and the L2 request/response port. Read misses allocate via a 4-beat L2 line refill. All writes are written through to L2; write misses do not allocate. Sits between the core load/store unit and the L2 cache.

## Interface
- LINES, 256, number of cache lines (power of 2)
- INDEX_W, 8, log2(LINES); tag width = 28-INDEX_W; address map tag [31:INDEX_W+4], index [INDEX_W+3:4], word [3:2], [1:0] ignored
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_req_valid  in  1  CPU request present
- cpu_req_ready  out  1  controller can accept (high only in IDLE)
- cpu_req_we  in  1  1=write, 0=read
- cpu_req_addr  in  32  byte address
- cpu_req_wdata  in  32  write data
- cpu_resp_valid  out  1  one-cycle completion pulse (read data or write ack)
- cpu_resp_rdata  out  32  read data; 0 for write ack
- l2_req_valid  out  1  L2 request
- l2_req_ready  in  1  L2 accepts request
- l2_req_we  out  1  1=write-through word, 0=line fetch
- l2_req_addr  out  32  line-aligned for fetch; word address for write
- l2_req_wdata  out  32  write-through data
- l2_resp_valid  in  1  refill beat valid
- l2_resp_rdata  in  32  refill beat data
- hit_count, miss_count  out  32  lookup statistics, wrap modulo 2^32

## Operation
- States: IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, WRITE_REQ, RESP.
- IDLE: cpu_req_ready=1; on cpu_req_valid capture addr/we/wdata and go to LOOKUP.
- LOOKUP: hit = valid[index] && tag[index]==addr tag. Exactly one of hit_count/miss_count increments per request.
  - Read hit -> RESP with rdata = data[index][word].
  - Read miss -> REFILL_REQ.
  - Write hit -> update data[index][word] this cycle, then WRITE_REQ.
  - Write miss -> WRITE_REQ; no allocation.
- REFILL_REQ: l2_req_valid=1, we=0, addr={tag,index,4'b0}; hold all fields stable until l2_req_ready, then REFILL_WAIT.
- REFILL_WAIT: 2-bit beat counter from 0. Each l2_resp_valid writes the beat to data[index][beat] and increments the counter. Capture the beat whose number equals the requested word. On beat 3, write the tag and set valid, then go to RESP. Line becomes valid only after the last beat.
- WRITE_REQ: l2_req_valid=1, we=1, addr={addr[31:2],2'b0}, wdata; hold until l2_req_ready, then RESP with rdata=0. No L2 write acknowledge is awaited.
- RESP: cpu_resp_valid=1 for one cycle, then IDLE.
- l2_resp_valid outside REFILL_WAIT is ignored.
- cpu_req_* are not sampled outside IDLE.

## Timing
- Reset (async): state IDLE; all valid bits 0; counters 0; cpu_resp_valid, cpu_resp_rdata, and all l2_req_* are 0. Tag and data arrays are not reset.
- Reset mid-refill or mid-write-through: abort to IDLE. The partially filled line stays invalid. Late L2 beats are ignored.
- All outputs are registered or decoded from state only; no combinational path from any input to any output.
- Read hit: accept at cycle T, LOOKUP at T+1, cpu_resp_valid at T+2, ready again at T+3. Peak throughput is one request per 3 cycles.
- Read miss: l2_req_valid at T+2. Response follows 1 cycle after the 4th beat. Beats may have gaps.
- Write: l2_req_valid at T+2. Response follows 1 cycle after the l2_req_valid && l2_req_ready handshake.
- l2_req_valid, once asserted, stays high with constant fields until l2_req_ready.

## Test plan
- Reset, read 0x0000_1234 -> miss_count=1, l2 fetch addr 0x0000_1230 we=0. Beats 0xA0,0xA1,0xA2,0xA3 -> cpu_resp_rdata=0xA1 one cycle after the 4th beat.
- Then read 0x0000_1238 -> hit_count=1, resp at T+2 with rdata 0xA2, no l2_req_valid.
- Write 0x0000_1234 data 0xDEAD_BEEF -> hit, l2 write addr 0x0000_1234 wdata 0xDEADBEEF. A following read of 0x0000_1234 hits and returns 0xDEADBEEF.
- Write 0x0000_5000 (invalid line) -> miss_count increments, L2 write issued. A subsequent read of 0x0000_5000 misses and refills.
- Conflict: read 0x0001_1230 (index 0x23, tag 0x00011) refills and evicts. A re-read of 0x0000_1230 misses.
- Hold l2_req_ready low 3 cycles: l2_req_valid/addr stay stable. Assert rst after 2 refill beats: all outputs 0, valid[0x23]=0, extra beats are ignored, and the next read of the same address misses.
